axi4lite_wr_slave_regs: RTL and testbench

AXI4LITE_WR_SLAVE_REGS -- requirements
Module: axi4lite_wr_slave_regs

---
 rtl/axi4lite_wr_slave_regs.sv | 153 +++++++++++++++
 tb/tb_axi4lite_wr_slave_regs.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_wr_slave_regs.sv
// AXI4-Lite write-only slave backed by a small register file.
// Accepts AW and W in either order, commits on entry to RESP, and exposes a side-band read port.
module axi4lite_wr_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  localparam int ADDR_LSB  = $clog2(STRB_WIDTH),
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BVALID,
  output logic [1:0]            BRESP,
  input  logic                  BREADY,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           wr_count,
  output logic [15:0]           err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [IDX_W:0]        NUM_REGS_I = (IDX_W + 1)'(NUM_REGS);

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;
  logic [1:0]            bresp_reg;
  logic [15:0]           wr_count_reg;
  logic [15:0]           err_count_reg;
  logic [DATA_WIDTH-1:0] reg_file [NUM_REGS];

  logic                  aw_hs, w_hs, b_hs, commit;
  logic [ADDR_WIDTH-1:0] eff_addr, idx_full;
  logic [DATA_WIDTH-1:0] eff_data, strb_mask;
  logic [STRB_WIDTH-1:0] eff_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  in_range;

  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (state_reg)
      IDLE:    begin AWREADY = 1'b1; WREADY = 1'b1; end
      HAVE_AW: WREADY = 1'b1;
      HAVE_W:  AWREADY = 1'b1;
      RESP:    BVALID = 1'b1;
      default: ;
    endcase
  end

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (aw_hs && w_hs) state_next = RESP;
        else if (aw_hs)    state_next = HAVE_AW;
        else if (w_hs)     state_next = HAVE_W;
      end
      HAVE_AW: if (w_hs)   state_next = RESP;
      HAVE_W:  if (aw_hs)  state_next = RESP;
      RESP:    if (BREADY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Whichever half arrives last is used straight from the bus on the commit edge.
  assign eff_addr = (state_reg == HAVE_AW) ? awaddr_reg : AWADDR;
  assign eff_data = (state_reg == HAVE_W)  ? wdata_reg  : WDATA;
  assign eff_strb = (state_reg == HAVE_W)  ? wstrb_reg  : WSTRB;
  assign commit   = (state_reg != RESP) && (state_next == RESP);
  assign idx_full = eff_addr >> ADDR_LSB;
  assign in_range = idx_full < NUM_REGS_A;
  assign wr_idx   = idx_full[IDX_W-1:0];

  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_mask
      assign strb_mask[gi*8 +: 8] = {8{eff_strb[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_reg <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
    end else begin
      if (aw_hs) awaddr_reg <= AWADDR;
      if (w_hs) begin
        wdata_reg <= WDATA;
        wstrb_reg <= WSTRB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
      bresp_reg <= 2'b00;
    end else if (commit) begin
      bresp_reg <= in_range ? 2'b00 : 2'b10;
      if (in_range)
        reg_file[wr_idx] <= (reg_file[wr_idx] & ~strb_mask) | (eff_data & strb_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_reg  <= '0;
      err_count_reg <= '0;
    end else if (b_hs) begin
      if (wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
      if (bresp_reg == 2'b10 && err_count_reg != 16'hFFFF)
        err_count_reg <= err_count_reg + 16'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < NUM_REGS_I) rd_data = reg_file[rd_idx];
  end

  assign BRESP     = bresp_reg;
  assign wr_count  = wr_count_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_axi4lite_wr_slave_regs.sv
// Directed bench for axi4lite_wr_slave_regs: table of simultaneous writes plus
// hand-written sequences for ordering, backpressure, mid-transaction reset and saturation.
module tb_axi4lite_wr_slave_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic [1:0]  BRESP;
  logic        BREADY;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic [15:0] wr_count;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_wr  = 16'd0;
  logic [15:0] exp_err = 16'd0;

  axi4lite_wr_slave_regs dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  idx;
    logic [1:0]  bresp;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [3:0] idx, input string name, input logic [31:0] exp);
    rd_idx = idx;
    #1;
    check(name, rd_data, exp);
  endtask

  // Called at a negedge; returns at the negedge where BVALID is seen (or the bound expires).
  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int extra);
    logic aw_f, w_f;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    for (int n = 0; n < 20 && (AWVALID || WVALID); n++) begin
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(posedge clk); @(negedge clk);
      if (aw_f) AWVALID = 1'b0;
      if (w_f)  WVALID  = 1'b0;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    extra = 0;
    while (!BVALID && extra < 20) begin
      @(negedge clk);
      extra++;
    end
  endtask

  task automatic finish_b(input logic is_err, input string name);
    BREADY = 1'b1;
    @(posedge clk); @(negedge clk);
    BREADY = 1'b0;
    if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
    if (is_err && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    check({name, " bvalid_after"}, BVALID, 1'b0);
    check({name, " idle_ready"}, {AWREADY, WREADY}, 2'b11);
    check({name, " wr_count"}, wr_count, exp_wr);
    check({name, " err_count"}, err_count, exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int extra;

    vecs[0] = '{32'h0000_0008, 32'hDEAD_BEEF, 4'hF,    4'd2,  2'b00, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0009, 32'h0000_00AA, 4'b0001, 4'd2,  2'b00, 32'hDEAD_BEAA};
    vecs[2] = '{32'h0000_000A, 32'h1234_5678, 4'h0,    4'd2,  2'b00, 32'hDEAD_BEAA};
    vecs[3] = '{32'h0000_003C, 32'hCAFE_F00D, 4'b1100, 4'd15, 2'b00, 32'hCAFE_0000};
    vecs[4] = '{32'h0000_0040, 32'hFFFF_FFFF, 4'hF,    4'd0,  2'b10, 32'h0000_0000};
    vecs[5] = '{32'h0000_0000, 32'h0102_0304, 4'b1010, 4'd0,  2'b00, 32'h0100_0300};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_5555, 4'hF,    4'd15, 2'b10, 32'hCAFE_0000};
    vecs[7] = '{32'h0000_0044, 32'h0000_0077, 4'hF,    4'd1,  2'b10, 32'h0000_0000};

    rst = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
    WVALID = 1'b0; BREADY = 1'b0; rd_idx = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst awready", AWREADY, 1'b1);
    check("rst wready", WREADY, 1'b1);
    check("rst bvalid", BVALID, 1'b0);
    rst = 1'b0;
    check("rst bresp", BRESP, 2'b00);
    check("rst wr_count", wr_count, 16'd0);
    check("rst err_count", err_count, 16'd0);
    peek(4'd0, "rst reg0", 32'd0);

    // Simultaneous AW/W table
    for (int i = 0; i < 8; i++) begin
      start_write(vecs[i].addr, vecs[i].data, vecs[i].strb, extra);
      check($sformatf("vec%0d latency", i), extra, 0);
      check($sformatf("vec%0d bvalid", i), BVALID, 1'b1);
      check($sformatf("vec%0d bresp", i), BRESP, vecs[i].bresp);
      check($sformatf("vec%0d resp_ready", i), {AWREADY, WREADY}, 2'b00);
      peek(vecs[i].idx, $sformatf("vec%0d rd_data", i), vecs[i].rd);
      finish_b(vecs[i].bresp == 2'b10, $sformatf("vec%0d", i));
      $display("vec%0d addr=%h data=%h strb=%b bresp=%b rd[%0d]=%h",
               i, vecs[i].addr, vecs[i].data, vecs[i].strb, BRESP, vecs[i].idx, rd_data);
    end

    // W three cycles ahead of AW, then 5 cycles of B backpressure
    WDATA = 32'h1122_3344; WSTRB = 4'b0101; WVALID = 1'b1;
    @(posedge clk); @(negedge clk);
    WVALID = 1'b0; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF;
    for (int n = 0; n < 3; n++) begin
      check("wfirst wready", WREADY, 1'b0);
      check("wfirst awready", AWREADY, 1'b1);
      check("wfirst bvalid", BVALID, 1'b0);
      if (n < 2) begin @(posedge clk); @(negedge clk); end
    end
    AWADDR = 32'h4; AWVALID = 1'b1;
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0; AWADDR = 32'h3C;
    check("wfirst bvalid_resp", BVALID, 1'b1);
    check("wfirst bresp", BRESP, 2'b00);
    peek(4'd1, "wfirst reg1", 32'h0022_0044);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); @(negedge clk);
      check("bp bvalid", BVALID, 1'b1);
      check("bp bresp", BRESP, 2'b00);
      check("bp ready", {AWREADY, WREADY}, 2'b00);
    end
    finish_b(1'b0, "wfirst");
    peek(4'd15, "wfirst reg15", 32'hCAFE_0000);
    $display("wfirst reg1=%h wr_count=%0d", 32'h0022_0044, wr_count);

    // AW ahead of W, address bus changes after its handshake
    AWADDR = 32'h14; AWVALID = 1'b1;
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0; AWADDR = 32'h18;
    check("awfirst ready", {AWREADY, WREADY}, 2'b01);
    check("awfirst bvalid", BVALID, 1'b0);
    WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge clk); @(negedge clk);
    WVALID = 1'b0;
    check("awfirst bvalid_resp", BVALID, 1'b1);
    check("awfirst bresp", BRESP, 2'b00);
    peek(4'd5, "awfirst reg5", 32'hA5A5_A5A5);
    peek(4'd6, "awfirst reg6", 32'h0);
    finish_b(1'b0, "awfirst");
    $display("awfirst reg5=%h", 32'hA5A5_A5A5);

    // Reset while holding an address
    AWADDR = 32'h8; AWVALID = 1'b1;
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0;
    check("midrst have_aw", {AWREADY, WREADY}, 2'b01);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_wr = 16'd0; exp_err = 16'd0;
    check("midrst bvalid", BVALID, 1'b0);
    check("midrst ready", {AWREADY, WREADY}, 2'b11);
    check("midrst wr_count", wr_count, 16'd0);
    check("midrst err_count", err_count, 16'd0);
    peek(4'd2, "midrst reg2", 32'h0);
    start_write(32'h8, 32'h0BAD_F00D, 4'hF, extra);
    check("postrst bvalid", BVALID, 1'b1);
    check("postrst bresp", BRESP, 2'b00);
    peek(4'd2, "postrst reg2", 32'h0BAD_F00D);
    finish_b(1'b0, "postrst");
    $display("postrst reg2=%h wr_count=%0d", 32'h0BAD_F00D, wr_count);

    // Saturation: preload both counters near the top
    force dut.wr_count_reg  = 16'hFFFE;
    force dut.err_count_reg = 16'hFFFE;
    #1;
    release dut.wr_count_reg;
    release dut.err_count_reg;
    @(negedge clk);
    exp_wr = 16'hFFFE; exp_err = 16'hFFFE;
    check("sat preload", wr_count, 16'hFFFE);
    start_write(32'h0, 32'h1, 4'hF, extra);
    finish_b(1'b0, "sat1");
    start_write(32'h80, 32'h1, 4'hF, extra);
    check("sat2 bresp", BRESP, 2'b10);
    finish_b(1'b1, "sat2");
    start_write(32'h80, 32'h1, 4'hF, extra);
    finish_b(1'b1, "sat3");
    $display("sat wr_count=%h err_count=%h", wr_count, err_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
